// File: rtl/video_write_queue.sv
// Character write queue between the CPU OUTCHAR path and the framebuffer write port.
// Writes drain only during blanking; `define VIDEO_CLEAR_EN adds a hardware screen-clear sweep.
module video_write_queue #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned ADDR_W       = 11,
    parameter int unsigned SCREEN_CHARS = 1200,
    parameter logic [15:0] BLANK_CHAR   = 16'h0000
) (
    input  logic                     wire_clock,
    input  logic                     wire_reset,
    input  logic                     videoflag,
    input  logic [15:0]              bus_vga_pos,
    input  logic [15:0]              bus_vga_char,
    input  logic                     wire_blank,
    input  logic                     clear_req,
    output logic                     fb_we,
    output logic [ADDR_W-1:0]        fb_addr,
    output logic [15:0]              fb_data,
    output logic                     fifo_full,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     range_err,
    output logic                     clear_busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t            state;
    logic              vflag_q;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [15:0]       mem_data [DEPTH];

    logic              push_req_c;
    logic              in_range_c;
    logic              pop_c;
    logic              push_c;
    logic              drop_c;
    logic [LVL_W-1:0]  level_nxt_c;

    // A request is one rising edge of videoflag; a pop is any blanking cycle with data outside a sweep.
    always_comb begin
        push_req_c  = videoflag & ~vflag_q;
        in_range_c  = bus_vga_pos < 16'(SCREEN_CHARS);
        pop_c       = (state != CLEAR) && (fifo_level != '0) && wire_blank;
        push_c      = push_req_c && in_range_c && (!fifo_full || pop_c);
        drop_c      = push_req_c && in_range_c && fifo_full && !pop_c;
        level_nxt_c = fifo_level + LVL_W'(push_c) - LVL_W'(pop_c);
    end

    // Queue storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge wire_clock) begin
        if (push_c) begin
            mem_addr[wr_ptr] <= bus_vga_pos[ADDR_W-1:0];
            mem_data[wr_ptr] <= bus_vga_char;
        end
    end

`ifdef VIDEO_CLEAR_EN
    logic [ADDR_W-1:0] clear_ctr;
`else
    logic unused_clear_req;
    assign unused_clear_req = clear_req;
    assign clear_busy       = 1'b0;
`endif

    always_ff @(posedge wire_clock or posedge wire_reset) begin
        if (wire_reset) begin
            state      <= IDLE;
            vflag_q    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            fifo_full  <= 1'b0;
            overflow   <= 1'b0;
            range_err  <= 1'b0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
`ifdef VIDEO_CLEAR_EN
            clear_ctr  <= '0;
            clear_busy <= 1'b0;
`endif
        end else begin
            vflag_q    <= videoflag;
            fifo_level <= level_nxt_c;
            fifo_full  <= (level_nxt_c == LVL_W'(DEPTH));
            fb_we      <= 1'b0;

            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                fb_we   <= 1'b1;
                fb_addr <= mem_addr[rd_ptr];
                fb_data <= mem_data[rd_ptr];
            end
            if (push_req_c && !in_range_c) begin
                range_err <= 1'b1;
            end
            if (drop_c) begin
                overflow <= 1'b1;
            end

`ifdef VIDEO_CLEAR_EN
            // Sweep one blank word per blanking cycle; queued writes resume afterwards.
            if (state == CLEAR) begin
                if (wire_blank) begin
                    fb_we   <= 1'b1;
                    fb_addr <= clear_ctr;
                    fb_data <= BLANK_CHAR;
                    if (clear_ctr == ADDR_W'(SCREEN_CHARS - 1)) begin
                        clear_busy <= 1'b0;
                        state      <= (level_nxt_c != '0) ? DRAIN : IDLE;
                    end else begin
                        clear_ctr <= clear_ctr + ADDR_W'(1);
                    end
                end
            end else if (clear_req) begin
                state      <= CLEAR;
                clear_ctr  <= '0;
                clear_busy <= 1'b1;
            end else
`endif
            state <= (level_nxt_c != '0) ? DRAIN : IDLE;
        end
    end

endmodule

// File: tb/tb_video_write_queue.sv
// Directed bench for video_write_queue: queue-based reference model checked every cycle,
// plus hand-computed literal expectations. Define VIDEO_CLEAR_EN to exercise the clear sweep.
module tb_video_write_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        videoflag = 1'b0;
    logic [15:0] pos = '0;
    logic [15:0] chr = '0;
    logic        blank = 1'b0;
    logic        clear_req = 1'b0;
    logic        fb_we;
    logic [10:0] fb_addr;
    logic [15:0] fb_data;
    logic        fifo_full;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic        range_err;
    logic        clear_busy;

    video_write_queue dut (
        .wire_clock   (clk),
        .wire_reset   (rst),
        .videoflag    (videoflag),
        .bus_vga_pos  (pos),
        .bus_vga_char (chr),
        .wire_blank   (blank),
        .clear_req    (clear_req),
        .fb_we        (fb_we),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .fifo_full    (fifo_full),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .range_err    (range_err),
        .clear_busy   (clear_busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending writes plus sticky flags.
    logic [26:0] m_q[$];
    logic        m_prev = 1'b0;
    logic        m_we = 1'b0;
    logic [10:0] m_addr = '0;
    logic [15:0] m_data = '0;
    logic        m_ovf = 1'b0;
    logic        m_rng = 1'b0;
    logic        m_clearing = 1'b0;
    int          m_idx = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_prev = 1'b0; m_we = 1'b0; m_addr = '0; m_data = '0;
            m_ovf = 1'b0; m_rng = 1'b0; m_clearing = 1'b0; m_idx = 0;
        end else begin
            logic        rise;
            logic        was_clearing;
            logic [26:0] e;
            rise         = videoflag && !m_prev;
            m_prev       = videoflag;
            was_clearing = m_clearing;
            m_we         = 1'b0;
            if (was_clearing) begin
                if (blank) begin
                    m_we   = 1'b1;
                    m_addr = 11'(m_idx);
                    m_data = 16'h0000;
                    m_idx++;
                    if (m_idx == 1200) m_clearing = 1'b0;
                end
            end else if (blank && m_q.size() > 0) begin
                e      = m_q.pop_front();
                m_we   = 1'b1;
                m_addr = e[26:16];
                m_data = e[15:0];
            end
            if (rise) begin
                if (pos >= 16'd1200)      m_rng = 1'b1;
                else if (m_q.size() >= 16) m_ovf = 1'b1;
                else                       m_q.push_back({pos[10:0], chr});
            end
`ifdef VIDEO_CLEAR_EN
            if (!was_clearing && clear_req) begin
                m_clearing = 1'b1;
                m_idx      = 0;
            end
`endif
        end
    end

    int          wr_cnt = 0;
    logic [10:0] last_addr = '0;
    logic [15:0] last_data = '0;
    int          max_lvl = 0;

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("fb_we", 32'(fb_we), 32'(m_we));
            if (m_we) begin
                chk("fb_addr", 32'(fb_addr), 32'(m_addr));
                chk("fb_data", 32'(fb_data), 32'(m_data));
            end
            chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
            chk("fifo_full", 32'(fifo_full), 32'(m_q.size() == 16));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("range_err", 32'(range_err), 32'(m_rng));
            chk("clear_busy", 32'(clear_busy), 32'(m_clearing));
            if (fb_we) begin
                wr_cnt++;
                last_addr = fb_addr;
                last_data = fb_data;
            end
            if (32'(fifo_level) > max_lvl) max_lvl = 32'(fifo_level);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [15:0] p, input logic [15:0] c);
        videoflag = 1'b1; pos = p; chr = c;
        step(1);
        videoflag = 1'b0;
        step(1);
    endtask

    int base;

    initial begin
        // Reset state
        #3;
        chk("rst_we", 32'(fb_we), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_flags", 32'({overflow, range_err, fifo_full, clear_busy}), 32'd0);
        step(2);
        rst = 1'b0;
        step(1);

        // Single write appears two edges after the rise
        blank = 1'b1;
        base  = wr_cnt;
        videoflag = 1'b1; pos = 16'd5; chr = 16'h0241;
        step(1);
        chk("sw_early_we", 32'(fb_we), 32'd0);
        videoflag = 1'b0;
        step(1);
        chk("sw_we", 32'(fb_we), 32'd1);
        chk("sw_addr", 32'(fb_addr), 32'd5);
        chk("sw_data", 32'(fb_data), 32'h0241);
        step(3);
        chk("sw_count", 32'(wr_cnt - base), 32'd1);

        // Held flag yields one entry
        base = wr_cnt;
        videoflag = 1'b1; pos = 16'd7; chr = 16'h0a0b;
        step(4);
        videoflag = 1'b0;
        step(3);
        chk("held_count", 32'(wr_cnt - base), 32'd1);

        // Burst during active video overflows after 16
        blank = 1'b0;
        for (int i = 0; i < 20; i++) pulse(16'(100 + i), 16'(16'h0100 + i));
        chk("burst_full", 32'(fifo_full), 32'd1);
        chk("burst_ovf", 32'(overflow), 32'd1);
        chk("burst_level", 32'(fifo_level), 32'd16);
        base  = wr_cnt;
        blank = 1'b1;
        step(20);
        chk("burst_count", 32'(wr_cnt - base), 32'd16);
        chk("burst_empty", 32'(fifo_level), 32'd0);

        // Range boundary
        base = wr_cnt;
        pulse(16'd1200, 16'h1111);
        step(2);
        chk("range_err", 32'(range_err), 32'd1);
        chk("range_nowrite", 32'(wr_cnt - base), 32'd0);
        pulse(16'd1199, 16'h2222);
        step(2);
        chk("range_last_addr", 32'(last_addr), 32'd1199);
        chk("range_last_data", 32'(last_data), 32'h2222);

        // Pointer wrap with blanking toggling every 3 cycles
        base    = wr_cnt;
        max_lvl = 0;
        for (int t = 0; t < 80; t++) begin
            blank     = ((t / 3) % 2) == 0;
            videoflag = (t % 2) == 0;
            pos       = 16'(200 + t / 2);
            chr       = 16'(16'h3000 + t / 2);
            step(1);
        end
        videoflag = 1'b0;
        blank     = 1'b1;
        step(20);
        chk("wrap_count", 32'(wr_cnt - base), 32'd40);
        chk("wrap_maxlvl", 32'(max_lvl <= 16), 32'd1);
        chk("wrap_empty", 32'(fifo_level), 32'd0);

        // Reset while draining
        blank = 1'b0;
        for (int i = 0; i < 8; i++) pulse(16'(400 + i), 16'(16'h4000 + i));
        chk("rmd_level", 32'(fifo_level), 32'd8);
        blank = 1'b1;
        step(1);
        chk("rmd_we_before", 32'(fb_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("rmd_we_async", 32'(fb_we), 32'd0);
        chk("rmd_level_async", 32'(fifo_level), 32'd0);
        step(1);
        rst = 1'b0;
        step(1);
        chk("rmd_flags", 32'({overflow, range_err, fifo_full}), 32'd0);
        chk("rmd_level_after", 32'(fifo_level), 32'd0);

`ifdef VIDEO_CLEAR_EN
        // Clear sweep; a push during the sweep lands after it
        base      = wr_cnt;
        clear_req = 1'b1;
        step(1);
        clear_req = 1'b0;
        chk("clr_busy", 32'(clear_busy), 32'd1);
        step(100);
        pulse(16'd3, 16'h1234);
        step(1200);
        chk("clr_done", 32'(clear_busy), 32'd0);
        chk("clr_count", 32'(wr_cnt - base), 32'd1201);
        chk("clr_last_addr", 32'(last_addr), 32'd3);
        chk("clr_last_data", 32'(last_data), 32'h1234);
`endif

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
